riscv_core_id_input_t: RTL and testbench

RISCV_CORE_ID_INPUT_T -- requirements
Module: riscv_core_id_input_t

---
 rtl/riscv_core_id_input_t_pkg.sv | 17 +
 rtl/riscv_core_id_skid_t.sv | 47 ++++
 rtl/riscv_core_id_input_t.sv | 167 ++++++++++++++++
 tb/tb_riscv_core_id_input_t.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_id_input_t_pkg.sv
// Shared ID-input definitions: the canonical NOP, FSM states and counter widths.
package riscv_core_id_input_t_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          DROP_W    = 2;
    localparam int          OUTST_W   = 3;
    localparam int          SUM_W     = OUTST_W + 1;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RSP = 2'd1,
        ST_HOLD     = 2'd2
    } id_state_e;

endpackage

// File: rtl/riscv_core_id_skid_t.sv
// One-entry holding register plus the mux that picks what decode sees:
// bubble first, then the held word, then the word arriving from memory.
module riscv_core_id_skid_t
    import riscv_core_id_input_t_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_discard,
    input  logic [31:0] i_rdata,
    input  logic        i_sel_direct,
    input  logic        i_sel_hold,
    input  logic        i_bubble,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic        o_bubble
);

    logic [31:0] r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= NOP_INSTR;
        end else if (i_discard) begin
            r_hold <= NOP_INSTR;
        end else if (i_load) begin
            r_hold <= i_rdata;
        end
    end

    always_comb begin
        o_instr  = NOP_INSTR;
        o_valid  = 1'b0;
        o_bubble = 1'b0;
        if (i_bubble) begin
            o_valid  = 1'b1;
            o_bubble = 1'b1;
        end else if (i_sel_hold) begin
            o_instr = r_hold;
            o_valid = 1'b1;
        end else if (i_sel_direct) begin
            o_instr = i_rdata;
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/riscv_core_id_input_t.sv
// ID-stage input: PC/clear/stall registers, fetch-response tracking FSM,
// drop counter for responses orphaned by a flush, and the sticky overrun flag.
module riscv_core_id_input_t
    import riscv_core_id_input_t_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] r_id_pc_D,
    input  logic        r_id_pc_WE,
    input  logic        r_id_clear_D,
    input  logic        r_id_clear_WE,
    input  logic        r_id_stall_D,
    input  logic        r_id_stall_WE,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        id_ready,
    output logic [31:0] r_id_pc_Q,
    output logic        r_id_clear_Q,
    output logic        r_id_stall_Q,
    output logic [31:0] id_instr_Q,
    output logic        id_valid,
    output logic        id_bubble,
    output logic        id_overrun
);

    id_state_e          r_state;
    id_state_e          w_state_next;
    logic [DROP_W-1:0]  r_drop;
    logic [DROP_W-1:0]  w_drop_next;
    logic [OUTST_W-1:0] r_outst;
    logic [OUTST_W-1:0] w_outst_next;
    logic [OUTST_W-1:0] w_outst_left;
    logic [SUM_W-1:0]   w_drop_sum;
    logic               w_drop_ovf;
    logic               r_overrun;
    logic               w_overrun_set;
    logic               w_fetch;
    logic               w_fetch_drop;
    logic               w_flush;
    logic               w_rsp;
    logic               w_discard;
    logic               w_accept;
    logic               w_outst_dec;
    logic               w_load_hold;
    logic               w_sel_direct;
    logic               w_sel_hold;

    assign w_fetch      = r_id_pc_WE & ~r_id_stall_D & ~r_id_clear_D;
    assign w_fetch_drop = r_id_pc_WE & ~r_id_stall_D &  r_id_clear_D;
    assign w_flush      = r_id_clear_WE & r_id_clear_D;
    assign w_discard    = imem_rvalid & (r_drop != '0);
    assign w_rsp        = imem_rvalid & (r_drop == '0);
    // A pending bubble owns the decode handshake, so a real word cannot retire under it.
    assign w_accept     = id_ready & ~r_id_clear_Q;
    assign w_outst_dec  = w_rsp & (r_outst != '0);
    assign w_sel_direct = (r_state == ST_WAIT_RSP) & w_rsp;
    assign w_sel_hold   = (r_state == ST_HOLD);
    assign id_overrun   = r_overrun;

    always_comb begin
        w_outst_next = r_outst;
        if (w_outst_dec) begin
            w_outst_next = w_outst_next - 1'b1;
        end
        if (w_fetch && (w_outst_next != '1)) begin
            w_outst_next = w_outst_next + 1'b1;
        end
        if (w_flush) begin
            w_outst_next = '0;
        end
    end

    // Every response still in flight at a flush becomes a future drop.
    always_comb begin
        w_outst_left = r_outst - {{(OUTST_W-1){1'b0}}, w_outst_dec};
        w_drop_sum   = SUM_W'(r_drop)
                     + (w_flush ? SUM_W'(w_outst_left) : '0)
                     + SUM_W'(w_fetch_drop)
                     - SUM_W'(w_discard);
        w_drop_ovf   = (w_drop_sum > SUM_W'(DROP_MAX));
        w_drop_next  = w_drop_ovf ? DROP_MAX : w_drop_sum[DROP_W-1:0];
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_hold   = 1'b0;
        w_overrun_set = w_drop_ovf;
        case (r_state)
            ST_IDLE: begin
                if (w_rsp) begin
                    w_overrun_set = 1'b1;
                end
                if (w_fetch) begin
                    w_state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (w_rsp) begin
                    if (w_accept) begin
                        w_state_next = (w_outst_next != '0) ? ST_WAIT_RSP : ST_IDLE;
                    end else begin
                        w_load_hold  = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_rsp) begin
                    w_overrun_set = 1'b1;
                end
                if (w_accept) begin
                    w_state_next = (w_outst_next != '0) ? ST_WAIT_RSP : ST_IDLE;
                end else if (w_fetch) begin
                    w_overrun_set = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_flush) begin
            w_state_next = ST_IDLE;
            w_load_hold  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_drop       <= '0;
            r_outst      <= '0;
            r_overrun    <= 1'b0;
            r_id_pc_Q    <= 32'h00000000;
            r_id_clear_Q <= 1'b0;
            r_id_stall_Q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_drop    <= w_drop_next;
            r_outst   <= w_outst_next;
            r_overrun <= r_overrun | w_overrun_set;
            if (r_id_pc_WE) begin
                r_id_pc_Q <= r_id_pc_D;
            end
            if (r_id_clear_WE) begin
                r_id_clear_Q <= r_id_clear_D;
            end
            if (r_id_stall_WE) begin
                r_id_stall_Q <= r_id_stall_D;
            end
        end
    end

    riscv_core_id_skid_t u_skid (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_load       (w_load_hold),
        .i_discard    (w_flush),
        .i_rdata      (imem_rdata),
        .i_sel_direct (w_sel_direct),
        .i_sel_hold   (w_sel_hold),
        .i_bubble     (r_id_clear_Q),
        .o_instr      (id_instr_Q),
        .o_valid      (id_valid),
        .o_bubble     (id_bubble)
    );

endmodule

// File: tb/tb_riscv_core_id_input_t.sv
// Randomized transaction-level bench: each fetch/flush episode predicts what decode
// must accept; a negedge monitor retires those predictions as handshakes happen.
module tb_riscv_core_id_input_t;
    import riscv_core_id_input_t_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] r_id_pc_D = '0;
    logic        r_id_pc_WE = 1'b0;
    logic        r_id_clear_D = 1'b0;
    logic        r_id_clear_WE = 1'b0;
    logic        r_id_stall_D = 1'b0;
    logic        r_id_stall_WE = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_rvalid = 1'b0;
    logic        id_ready = 1'b0;
    logic [31:0] r_id_pc_Q;
    logic        r_id_clear_Q;
    logic        r_id_stall_Q;
    logic [31:0] id_instr_Q;
    logic        id_valid;
    logic        id_bubble;
    logic        id_overrun;

    typedef struct {
        logic [31:0] instr;
        logic        bubble;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    riscv_core_id_input_t dut (
        .CLK           (CLK),
        .RST           (RST),
        .r_id_pc_D     (r_id_pc_D),
        .r_id_pc_WE    (r_id_pc_WE),
        .r_id_clear_D  (r_id_clear_D),
        .r_id_clear_WE (r_id_clear_WE),
        .r_id_stall_D  (r_id_stall_D),
        .r_id_stall_WE (r_id_stall_WE),
        .imem_rdata    (imem_rdata),
        .imem_rvalid   (imem_rvalid),
        .id_ready      (id_ready),
        .r_id_pc_Q     (r_id_pc_Q),
        .r_id_clear_Q  (r_id_clear_Q),
        .r_id_stall_Q  (r_id_stall_Q),
        .id_instr_Q    (id_instr_Q),
        .id_valid      (id_valid),
        .id_bubble     (id_bubble),
        .id_overrun    (id_overrun)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic pcWe, input logic [31:0] pc,
                                 input logic clrWe, input logic clrD,
                                 input logic stlWe, input logic stlD,
                                 input logic rv, input logic [31:0] rd, input logic rdy);
        r_id_pc_WE    = pcWe;
        r_id_pc_D     = pc;
        r_id_clear_WE = clrWe;
        r_id_clear_D  = clrD;
        r_id_stall_WE = stlWe;
        r_id_stall_D  = stlD;
        imem_rvalid   = rv;
        imem_rdata    = rd;
        id_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    // Fetch, response after lat cycles, decode back-pressures for stall cycles.
    task automatic runFetch(input logic [31:0] pc, input logic [31:0] word, input int lat, input int stall);
        applyStimulus(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 1; i < lat; i++) begin
            applyStimulus(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            @(negedge CLK);
            checkFlag("wait_valid", id_valid, 1'b0);
            tick();
        end
        applyStimulus(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, word, stall == 0);
        if (stall == 0) expQ.push_back('{word, 1'b0});
        @(negedge CLK);
        checkOutput("pc_q", r_id_pc_Q, pc);
        checkOutput("rsp_instr", id_instr_Q, word);
        tick();
        for (int s = 1; s <= stall; s++) begin
            applyStimulus(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, s == stall);
            if (s == stall) expQ.push_back('{word, 1'b0});
            @(negedge CLK);
            checkFlag("hold_valid", id_valid, 1'b1);
            checkOutput("hold_instr", id_instr_Q, word);
            tick();
        end
        applyStimulus(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge CLK);
        checkFlag("idle_valid", id_valid, 1'b0);
        tick();
    endtask

    // Fetch, flush before the response; the late response must vanish behind bubbles.
    task automatic runFlush(input logic [31:0] pc, input logic [31:0] word, input int bub);
        logic rdy;
        applyStimulus(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, pc, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkFlag("clear_q_set", r_id_clear_Q, 1'b1);
        for (int b = 0; b < bub; b++) begin
            rdy = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, pc, b == bub - 1, 1'b0, 1'b0, 1'b0, b == 0, word, rdy);
            if (rdy) expQ.push_back('{NOP_INSTR, 1'b1});
            @(negedge CLK);
            checkFlag("bubble_flag", id_bubble, 1'b1);
            checkOutput("bubble_instr", id_instr_Q, NOP_INSTR);
            tick();
        end
        checkFlag("clear_q_rel", r_id_clear_Q, 1'b0);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (id_valid && id_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got instr=%h bubble=%b, required no acceptance",
                             id_instr_Q, id_bubble);
                end else begin
                    monExp = expQ.pop_front();
                    if (id_instr_Q !== monExp.instr || id_bubble !== monExp.bubble) begin
                        errors++;
                        $display("[TB] FAIL sb_accept: got instr=%h bubble=%b, required instr=%h bubble=%b",
                                 id_instr_Q, id_bubble, monExp.instr, monExp.bubble);
                    end
                end
            end else if (!id_valid) begin
                checks++;
                if (id_instr_Q !== NOP_INSTR) begin
                    errors++;
                    $display("[TB] FAIL idle_instr: got %h, required %h", id_instr_Q, NOP_INSTR);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] word;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        checkOutput("rst_pc", r_id_pc_Q, 32'h0);
        checkFlag("rst_clear", r_id_clear_Q, 1'b0);
        checkFlag("rst_stall", r_id_stall_Q, 1'b0);
        checkFlag("rst_valid", id_valid, 1'b0);
        checkFlag("rst_bubble", id_bubble, 1'b0);
        checkFlag("rst_overrun", id_overrun, 1'b0);
        checkOutput("rst_instr", id_instr_Q, NOP_INSTR);
        doReset();

        $display("[TB] register load/hold");
        applyStimulus(1'b1, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        checkFlag("stall_no_bypass", r_id_stall_Q, 1'b0);
        tick();
        checkFlag("stall_load", r_id_stall_Q, 1'b1);
        checkOutput("pc_load", r_id_pc_Q, 32'hDEAD0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkFlag("stall_hold", r_id_stall_Q, 1'b1);
        checkOutput("pc_hold", r_id_pc_Q, 32'hDEAD0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkFlag("stall_unload", r_id_stall_Q, 1'b0);

        $display("[TB] directed fetch, back-pressure, flush");
        runFetch(32'h00000100, 32'h00A00093, 1, 0);
        runFetch(32'h00000100, 32'h00A00093, 1, 3);
        runFlush(32'h00000104, 32'h00B00113, 2);
        runFetch(32'h00000108, 32'h00C00193, 2, 1);

        $display("[TB] randomized episodes");
        for (int n = 0; n < 40; n++) begin
            pc   = $urandom & 32'hFFFF_FFFC;
            word = $urandom;
            if ($urandom_range(0, 3) == 0) runFlush(pc, word, int'($urandom_range(1, 3)));
            else runFetch(pc, word, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        end
        checkFlag("overrun_clean", id_overrun, 1'b0);
        checkOutput("sb_drained", 32'(expQ.size()), 32'h0);

        $display("[TB] drop counter saturation");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkFlag("sat_overrun", id_overrun, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b1);
            @(negedge CLK);
            checkFlag("drop_valid", id_valid, 1'b0);
            tick();
        end
        checkFlag("sat_overrun_sticky", id_overrun, 1'b1);

        $display("[TB] spurious response in idle");
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1);
        @(negedge CLK);
        checkFlag("spur_valid", id_valid, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkFlag("spur_overrun", id_overrun, 1'b1);

        $display("[TB] reset while holding");
        doReset();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE0013, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        checkOutput("hold_word", id_instr_Q, 32'hCAFE0013);
        tick();
        checkFlag("hold_fetch_overrun", id_overrun, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkFlag("pre_rst_stall", r_id_stall_Q, 1'b1);
        checkFlag("pre_rst_valid", id_valid, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        checkFlag("arst_valid", id_valid, 1'b0);
        checkFlag("arst_bubble", id_bubble, 1'b0);
        checkOutput("arst_instr", id_instr_Q, NOP_INSTR);
        checkOutput("arst_pc", r_id_pc_Q, 32'h0);
        checkFlag("arst_clear", r_id_clear_Q, 1'b0);
        checkFlag("arst_stall", r_id_stall_Q, 1'b0);
        checkFlag("arst_overrun", id_overrun, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
